// File: rtl/ccsds_turbo_enc_src_arb.sv
//==============================================================================
// Module   : ccsds_turbo_enc_src_arb
// Purpose  : Round-robin frame-source arbiter feeding a CCSDS turbo encoder.
//            Define CCSDS_TURBO_ENC_ARB_LEN_CHECK_EN to add frame-length checking.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ccsds_turbo_enc_src_arb #(
    parameter int pTAG_W = 8,
    parameter int pREQ_N = 4
) (
    input  logic                          iclk,
    input  logic                          ireset,
    input  logic                          iclkena,
    input  logic [pREQ_N-1:0]             ireq,
    input  logic [2*pREQ_N-1:0]           ireq_code,
    input  logic [2*pREQ_N-1:0]           ireq_nidx,
    input  logic [pTAG_W*pREQ_N-1:0]      ireq_tag,
    input  logic [pREQ_N-1:0]             isop,
    input  logic [pREQ_N-1:0]             ieop,
    input  logic [pREQ_N-1:0]             ival,
    input  logic [pREQ_N-1:0]             idat,
    output logic [pREQ_N-1:0]             oack,
    input  logic                          ienc_rdy,
    output logic [1:0]                    ocode,
    output logic [1:0]                    onidx,
    output logic [pTAG_W-1:0]             otag,
    output logic [$clog2(pREQ_N)-1:0]     osrc,
    output logic                          osop,
    output logic                          oeop,
    output logic                          oval,
    output logic                          odat,
    output logic                          oerr,
    output logic [$clog2(pREQ_N)-1:0]     oerr_src
);

    localparam int SRC_W = $clog2(pREQ_N);
    localparam logic [pREQ_N-1:0] c_ONE_HOT0 = pREQ_N'(1);

`ifdef CCSDS_TURBO_ENC_ARB_LEN_CHECK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DRAIN = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1} state_t;
`endif

    state_t             state_q;
    logic [SRC_W-1:0]   rr_q;
    logic [SRC_W-1:0]   rr_d;
    logic [SRC_W-1:0]   win_d;
    logic               found_d;
    logic               first_q;
    logic               sel_val;
    logic               sel_dat;
    logic               sel_eop;
    logic               unused_isop;

    // Frames are delimited internally; the sources' sop markers carry no information.
    assign unused_isop = ^isop;

    assign sel_val = ival[osrc];
    assign sel_dat = idat[osrc];
    assign sel_eop = ieop[osrc];

    always_comb begin
        logic [SRC_W-1:0] cand;
        found_d = 1'b0;
        win_d   = '0;
        cand    = '0;
        for (int k = 0; k < pREQ_N; k++) begin
            cand = SRC_W'((int'(rr_q) + k) % pREQ_N);
            if (!found_d && ireq[cand]) begin
                found_d = 1'b1;
                win_d   = cand;
            end
        end
        rr_d = (win_d == SRC_W'(pREQ_N - 1)) ? '0 : win_d + 1'b1;
    end

`ifdef CCSDS_TURBO_ENC_ARB_LEN_CHECK_EN
    logic [13:0]        cnt_q;
    logic [13:0]        cnt_d;
    logic [13:0]        frame_len;
    logic               err_q;
    logic [SRC_W-1:0]   err_src_q;

    assign cnt_d    = cnt_q + 14'd1;
    assign oerr     = err_q;
    assign oerr_src = err_src_q;

    always_comb begin
        case (onidx)
            2'd0:    frame_len = 14'd1784;
            2'd1:    frame_len = 14'd3568;
            2'd2:    frame_len = 14'd7136;
            default: frame_len = 14'd8920;
        endcase
    end
`else
    assign oerr     = 1'b0;
    assign oerr_src = '0;
`endif

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            first_q <= 1'b0;
            oack    <= '0;
            osop    <= 1'b0;
            oeop    <= 1'b0;
            oval    <= 1'b0;
            odat    <= 1'b0;
            ocode   <= '0;
            onidx   <= '0;
            otag    <= '0;
            osrc    <= '0;
`ifdef CCSDS_TURBO_ENC_ARB_LEN_CHECK_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_src_q <= '0;
`endif
        end else if (iclkena) begin
            osop <= 1'b0;
            oeop <= 1'b0;
            oval <= 1'b0;
            odat <= 1'b0;
`ifdef CCSDS_TURBO_ENC_ARB_LEN_CHECK_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    // Holding off while oeop is high guarantees an idle gap between frames.
                    if (found_d && ienc_rdy && !oeop) begin
                        state_q <= XFER;
                        oack    <= c_ONE_HOT0 << win_d;
                        ocode   <= ireq_code[2*win_d +: 2];
                        onidx   <= ireq_nidx[2*win_d +: 2];
                        otag    <= ireq_tag[pTAG_W*win_d +: pTAG_W];
                        osrc    <= win_d;
                        rr_q    <= rr_d;
                        first_q <= 1'b1;
`ifdef CCSDS_TURBO_ENC_ARB_LEN_CHECK_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                XFER: begin
                    oval <= sel_val;
                    odat <= sel_dat;
                    if (sel_val) begin
                        first_q <= 1'b0;
                        osop    <= first_q;
`ifdef CCSDS_TURBO_ENC_ARB_LEN_CHECK_EN
                        cnt_q   <= cnt_d;
                        if (sel_eop) begin
                            oeop    <= 1'b1;
                            oack    <= '0;
                            state_q <= IDLE;
                            if (cnt_d != frame_len) begin
                                err_q     <= 1'b1;
                                err_src_q <= osrc;
                            end
                        end else if (cnt_d == frame_len) begin
                            // Over-long frame: close it here and swallow the remainder.
                            oeop      <= 1'b1;
                            err_q     <= 1'b1;
                            err_src_q <= osrc;
                            state_q   <= DRAIN;
                        end
`else
                        if (sel_eop) begin
                            oeop    <= 1'b1;
                            oack    <= '0;
                            state_q <= IDLE;
                        end
`endif
                    end
                end
`ifdef CCSDS_TURBO_ENC_ARB_LEN_CHECK_EN
                DRAIN: begin
                    if (sel_val && sel_eop) begin
                        oack    <= '0;
                        state_q <= IDLE;
                    end
                end
`endif
                default: begin
                    oack    <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ccsds_turbo_enc_src_arb.sv
//==============================================================================
// Module   : tb_ccsds_turbo_enc_src_arb
// Purpose  : Randomized self-checking bench for ccsds_turbo_enc_src_arb against
//            a frame-level round-robin reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ccsds_turbo_enc_src_arb;

    localparam int TW = 8;
    localparam int RN = 4;
`ifdef CCSDS_TURBO_ENC_ARB_LEN_CHECK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    logic              iclk = 1'b0;
    logic              ireset = 1'b0;
    logic              iclkena = 1'b1;
    logic              ienc_rdy = 1'b1;
    logic [RN-1:0]     ireq = '0;
    logic [2*RN-1:0]   ireq_code = '0;
    logic [2*RN-1:0]   ireq_nidx = '0;
    logic [TW*RN-1:0]  ireq_tag = '0;
    logic [RN-1:0]     isop = '0, ieop = '0, ival = '0, idat = '0;
    logic [RN-1:0]     oack;
    logic [1:0]        ocode, onidx;
    logic [TW-1:0]     otag;
    logic [1:0]        osrc, oerr_src;
    logic              osop, oeop, oval, odat, oerr;

    ccsds_turbo_enc_src_arb #(.pTAG_W(TW), .pREQ_N(RN)) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
        .ireq(ireq), .ireq_code(ireq_code), .ireq_nidx(ireq_nidx), .ireq_tag(ireq_tag),
        .isop(isop), .ieop(ieop), .ival(ival), .idat(idat),
        .oack(oack), .ienc_rdy(ienc_rdy),
        .ocode(ocode), .onidx(onidx), .otag(otag), .osrc(osrc),
        .osop(osop), .oeop(oeop), .oval(oval), .odat(odat),
        .oerr(oerr), .oerr_src(oerr_src)
    );

    always #5 iclk = ~iclk;

    int n_chk = 0;
    int n_pass = 0;

    // source-side frame state
    int          len [RN];
    int          pos [RN];
    int          left[RN];
    int unsigned seed[RN];
    logic [1:0]  s_code[RN], s_nidx[RN];
    logic [TW-1:0] s_tag[RN];
    int lo_len = 10, hi_len = 40;
    int gap_pct = 0, ena_pct = 0, rdy_pct = 0;

    // reference model of the arbiter's observable behaviour
    logic [RN-1:0] m_ack;
    logic [1:0]    m_code, m_nidx;
    logic [TW-1:0] m_tag;
    int            m_src, m_err_src, rr, fwd;
    logic          m_val, m_dat, m_sop, m_eop, m_err;
    bit            drain;
    int            grants[$];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic fbit(input int unsigned sd, input int p);
        logic [31:0] x;
        x = sd ^ (32'(p) * 32'h9E3779B9);
        return x[17] ^ x[3] ^ x[29];
    endfunction

    function automatic int flen(input logic [1:0] n);
        case (n)
            2'd0:    return 1784;
            2'd1:    return 3568;
            2'd2:    return 7136;
            default: return 8920;
        endcase
    endfunction

    task automatic load(input int s, input int l, input logic [1:0] c, input logic [1:0] n,
                        input logic [TW-1:0] t);
        len[s] = l; pos[s] = 0; s_code[s] = c; s_nidx[s] = n; s_tag[s] = t; seed[s] = $urandom;
    endtask

    task automatic load_rand(input int s);
        load(s, int'($urandom_range(lo_len, hi_len)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    endtask

    task automatic model_reset();
        m_ack = '0; m_code = '0; m_nidx = '0; m_tag = '0; m_src = 0; m_err_src = 0;
        m_val = 0; m_dat = 0; m_sop = 0; m_eop = 0; m_err = 0;
        rr = 0; fwd = 0; drain = 0;
        for (int s = 0; s < RN; s++) pos[s] = 0;
    endtask

    task automatic drive();
        for (int s = 0; s < RN; s++) begin
            ireq[s] = (len[s] > 0);
            ireq_code[2*s +: 2] = s_code[s];
            ireq_nidx[2*s +: 2] = s_nidx[s];
            ireq_tag[TW*s +: TW] = s_tag[s];
            if (m_ack[s] && pos[s] < len[s]) begin
                ival[s] = ($urandom_range(0, 99) >= gap_pct);
                idat[s] = fbit(seed[s], pos[s]);
                ieop[s] = (pos[s] == len[s] - 1);
            end else begin
                ival[s] = 1'($urandom);
                idat[s] = 1'($urandom);
                ieop[s] = 1'($urandom);
            end
            isop[s] = 1'($urandom);
        end
        iclkena  = ($urandom_range(0, 99) >= ena_pct);
        ienc_rdy = ($urandom_range(0, 99) >= rdy_pct);
    endtask

    // one granted bit accepted by the arbiter
    task automatic consume(input int s);
        logic last, over, shrt;
        last = ieop[s];
        if (!drain) begin
            fwd++;
            over  = LEN_CHK && (fwd == flen(m_nidx)) && !last;
            shrt  = LEN_CHK && last && (fwd != flen(m_nidx));
            m_val = 1; m_dat = idat[s]; m_sop = (fwd == 1);
            m_eop = last || over;
            m_err = over || shrt;
            if (m_err) m_err_src = s;
            if (over) drain = 1;
        end else begin
            m_val = 0; m_sop = 0; m_eop = 0; m_err = 0;
            if (last) drain = 0;
        end
        pos[s]++;
        if (last) begin
            m_ack = '0;
            left[s]--;
            if (left[s] > 0) load_rand(s);
            else len[s] = 0;
        end
    endtask

    task automatic model_step();
        bit prev_eop;
        int w;
        if (m_ack == '0) begin
            prev_eop = m_eop;
            m_val = 0; m_sop = 0; m_eop = 0; m_err = 0;
            if (!prev_eop && ienc_rdy && ireq != '0) begin
                w = -1;
                for (int k = 0; k < RN; k++)
                    if (w < 0 && ireq[(rr + k) % RN]) w = (rr + k) % RN;
                m_ack  = RN'(1) << w;
                m_src  = w;
                m_code = ireq_code[2*w +: 2];
                m_nidx = ireq_nidx[2*w +: 2];
                m_tag  = ireq_tag[TW*w +: TW];
                rr = (w + 1) % RN; fwd = 0; drain = 0;
                grants.push_back(w);
            end
        end else if (ival[m_src]) begin
            consume(m_src);
        end else begin
            m_val = 0; m_sop = 0; m_eop = 0; m_err = 0;
        end
    endtask

    task automatic compare_all();
        chk_eq("oack", 32'(oack), 32'(m_ack));
        chk_eq("oval", 32'(oval), 32'(m_val));
        if (m_val) chk_eq("odat", 32'(odat), 32'(m_dat));
        chk_eq("osop", 32'(osop), 32'(m_sop));
        chk_eq("oeop", 32'(oeop), 32'(m_eop));
        chk_eq("ocode", 32'(ocode), 32'(m_code));
        chk_eq("onidx", 32'(onidx), 32'(m_nidx));
        chk_eq("otag", 32'(otag), 32'(m_tag));
        chk_eq("osrc", 32'(osrc), 32'(m_src));
        chk_eq("oerr", 32'(oerr), 32'(m_err));
        chk_eq("oerr_src", 32'(oerr_src), 32'(m_err_src));
    endtask

    task automatic cycle();
        @(posedge iclk);
        if (ireset && iclkena) model_step();
        #1;
        compare_all();
        drive();
    endtask

    function automatic bit busy();
        bit b;
        b = (m_ack != '0) || m_eop;
        for (int s = 0; s < RN; s++) if (len[s] > 0) b = 1;
        return b;
    endfunction

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            cycle();
            n++;
        end
        chk_eq("done_in_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic async_reset();
        #2 ireset = 1'b0;
        #1;
        chk_eq("rst_async", {6'd0, oack, osop, oeop, oval, odat, oerr, ocode, onidx, otag, osrc, oerr_src}, 32'd0);
        model_reset();
        grants.delete();
        cycle();
        cycle();
        ireset = 1'b1;
    endtask

    initial begin
        int n;
        for (int s = 0; s < RN; s++) begin
            len[s] = 0; left[s] = 0; seed[s] = 0;
            s_code[s] = '0; s_nidx[s] = '0; s_tag[s] = '0;
        end
        model_reset();
        drive();
        repeat (3) cycle();
        ireset = 1'b1;

        // single source, nominal 1784-bit frame
        left[2] = 1;
        load(2, 1784, 2'd1, 2'd0, 8'hA5);
        drive();
        run_until_idle(4000);
        chk_eq("single_src_grant", 32'(grants.size() > 0 ? grants[0] : -1), 32'd2);

        // all sources back-to-back from reset: strict rotation
        async_reset();
        lo_len = 20; hi_len = 60;
        for (int s = 0; s < RN; s++) begin left[s] = 2; load_rand(s); end
        drive();
        run_until_idle(3000);
        chk_eq("rr_grant_cnt", 32'(grants.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            chk_eq("rr_grant_order", 32'(grants.size() > i ? grants[i] : -1), 32'(i % RN));

        // encoder not ready holds off the grant; mid-frame drop does not stall
        rdy_pct = 100;
        left[1] = 1;
        load_rand(1);
        drive();
        repeat (50) cycle();
        chk_eq("no_grant_while_busy", 32'(oack), 32'd0);
        rdy_pct = 0;
        ienc_rdy = 1'b1;
        cycle();
        chk_eq("grant_after_rdy", 32'(oack), 32'b0010);
        rdy_pct = 100;
        run_until_idle(500);
        rdy_pct = 0;

        // randomized traffic with gaps, clock-enable holes and encoder back-pressure
        gap_pct = 25; ena_pct = 10; rdy_pct = 30; lo_len = 1; hi_len = 50;
        for (int s = 0; s < RN; s++) begin left[s] = int'($urandom_range(2, 4)); load_rand(s); end
        drive();
        run_until_idle(8000);
        gap_pct = 0; ena_pct = 0; rdy_pct = 0;

        // over-long frame (1800 bits, N = 1784)
        left[1] = 1;
        load(1, 1800, 2'd0, 2'd0, 8'h3C);
        drive();
        run_until_idle(3000);

        // short frame (3000 bits, N = 3568)
        left[0] = 1;
        load(0, 3000, 2'd2, 2'd1, 8'h5A);
        drive();
        run_until_idle(4000);

        // reset in the middle of a frame, then arbitration restarts from source 0
        left[3] = 1;
        load(3, 1000, 2'd3, 2'd2, 8'hC3);
        drive();
        n = 0;
        while (pos[3] < 500 && n < 2000) begin
            cycle();
            n++;
        end
        chk_eq("reached_bit500", 32'(pos[3] >= 500), 32'd1);
        async_reset();
        lo_len = 5; hi_len = 20;
        for (int s = 0; s < 3; s++) begin left[s] = 1; load_rand(s); end
        drive();
        run_until_idle(3000);
        chk_eq("first_after_reset", 32'(grants.size() > 0 ? grants[0] : -1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ccsds_turbo_enc_src_arb.md
CCSDS_TURBO_ENC_SRC_ARB -- requirements
Module: ccsds_turbo_enc_src_arb

Interface
REQ-001 SHALL have parameter pTAG_W, default 8, user tag width forwarded to the encoder.
REQ-002 SHALL have parameter pREQ_N, default 4, number of frame sources (2..8).
REQ-003 SHALL have port iclk, input, 1, the single clock.
REQ-004 SHALL have port ireset, input, 1, asynchronous active-low reset (0 = reset).
REQ-005 SHALL have port iclkena, input, 1, clock enable; all state SHALL hold when it is 0.
REQ-006 SHALL have port ireq, input, pREQ_N, per-source "frame ready" level.
REQ-007 SHALL have ports ireq_code / ireq_nidx, input, pREQ_N x 2 each, per-source code rate and length index.
REQ-008 SHALL have port ireq_tag, input, pREQ_N x pTAG_W, per-source tag.
REQ-009 SHALL have ports isop / ieop / ival / idat, input, pREQ_N each, per-source bit stream.
REQ-010 SHALL have port oack, output, pREQ_N, one-hot grant; a source streams only while its bit is 1.
REQ-011 SHALL have port ienc_rdy, input, 1, encoder ordy.
REQ-012 SHALL have ports ocode / onidx / otag / osrc, output, 2 / 2 / pTAG_W / $clog2(pREQ_N), frame parameters and source index.
REQ-013 SHALL have ports osop / oeop / oval / odat, output, 1 each, the stream to the encoder input.
REQ-014 SHALL have ports oerr / oerr_src, output, 1 / $clog2(pREQ_N), length error pulse and the offending source.

Function
REQ-015 FSM states SHALL be IDLE, XFER and DRAIN; DRAIN exists only with the macro in REQ-030.
REQ-016 IDLE->XFER SHALL occur when any ireq=1 and ienc_rdy=1; the winner is the first requesting source at or after rr_ptr, wrapping modulo pREQ_N.
REQ-017 On grant, the block SHALL latch the winner's code, nidx and tag into ocode, onidx, otag and osrc, which then stay constant until the next grant.
REQ-018 On grant, rr_ptr SHALL be set to winner+1 mod pREQ_N.
REQ-019 oack SHALL be 1 for the winner throughout XFER and DRAIN; it SHALL be 0 in IDLE.
REQ-020 ienc_rdy SHALL be sampled only in IDLE; a deassertion during XFER SHALL NOT stall the transfer.
REQ-021 Forwarding SHALL be registered with 1-cycle latency: oval/odat follow the granted ival/idat.
REQ-022 osop SHALL be 1 on the first forwarded bit of the frame; the source isop SHALL be ignored.
REQ-023 When the granted ival=1 and ieop=1, the block SHALL assert oeop on that bit and enter IDLE on the following cycle.
REQ-024 A new grant SHALL NOT be issued in the same cycle as oeop.
REQ-025 Inputs from non-granted sources SHALL be ignored.
REQ-026 The bit counter SHALL be 14 bits; the frame length N SHALL be 1784, 3568, 7136 or 8920 for nidx 0..3.

Reset
REQ-027 While ireset=0, the block SHALL set the state to IDLE, rr_ptr to 0, the bit counter to 0, and oack, osop, oeop, oval, odat, oerr, ocode, onidx, otag, osrc and oerr_src all to 0.
REQ-028 If reset asserts mid-frame, the frame SHALL be abandoned with no oeop; on release, arbitration SHALL restart from source 0.
REQ-029 Reset release SHALL take effect on the first iclk edge after ireset=1.

Configuration
REQ-030 Macro CCSDS_TURBO_ENC_ARB_LEN_CHECK_EN SHALL compile length checking in or out.
REQ-031 With the macro, a source ieop arriving at bit count != N SHALL pulse oerr for 1 cycle with oerr_src set; the short frame is still forwarded with oeop.
REQ-032 With the macro, when the N-th bit arrives without ieop, the block SHALL force oeop on that bit, pulse oerr, enter DRAIN and discard granted bits until ieop; the state SHALL then go to IDLE.
REQ-033 Without the macro, there SHALL be no counter and no DRAIN state, oerr and oerr_src SHALL be constant 0, and frames SHALL end only on the source ieop.

Verification
REQ-034 Source 2 alone requests, nidx=0, code=1, 1784 bits -> oack=0b0100; osop on the first bit; oeop on bit 1784, 1 cycle after the source's ieop; ocode=1, osrc=2; oerr=0.
REQ-035 All 4 sources request continuously for 8 frames -> grant order 0,1,2,3,0,1,2,3, with at least one idle cycle between oeop and the next oack.
REQ-036 ireq=1 with ienc_rdy=0 for 50 cycles, then ienc_rdy=1 -> no oack for those 50 cycles; grant follows on the next cycle; dropping ienc_rdy mid-frame does not stall.
REQ-037 Macro on, nidx=1, source ieop at bit 3000 -> oeop on bit 3000, oerr pulse with oerr_src set to the source; macro off -> oerr stays 0.
REQ-038 Macro on, nidx=0, source sends 1800 bits -> oeop forced on bit 1784, oerr=1, bits 1785..1800 not forwarded, IDLE after the source's ieop.
REQ-039 ireset=0 at bit 500 of a frame -> all outputs 0 asynchronously; after release, source 0 wins first.
